// File: rtl/posit_mul_ctrl.sv
// posit_mul_ctrl: sequencing controller for the posit multiplier pipeline.
// It accepts one operation per start/ready handshake and holds the pipeline
// stages in reset while idle. ZERO and NaR operands, and exponent-adder
// underflow or overflow, are resolved here, so the datapath result is bypassed.
// It also registers the final word, the class flags and a one-cycle done pulse.
// Optional feature: define POSIT_MUL_WDT_EN to enable a watchdog.
// The watchdog aborts an operation that stalls in DECODE/RUN for TIMEOUT_CYCLES.
module posit_mul_ctrl #(
    parameter int N              = 32,
    parameter int NUM_STAGES     = 5,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  ready,
    input  logic                  dec_valid,
    input  logic                  zero_a,
    input  logic                  nar_a,
    input  logic                  zero_b,
    input  logic                  nar_b,
    input  logic                  exp_valid,
    input  logic                  zero_exp,
    input  logic                  nar_exp,
    input  logic                  enc_done,
    input  logic [N-1:0]          enc_result,
    output logic [NUM_STAGES-1:0] stage_rst_n,
    output logic [N-1:0]          result,
    output logic                  nar,
    output logic                  zero,
    output logic                  done,
    output logic                  timeout
);

    localparam logic [N-1:0] NAR_PATTERN = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_RUN,
        S_SPECIAL,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [N-1:0]          result_q, result_d;
    logic                  nar_q, nar_d;
    logic                  zero_q, zero_d;
    logic                  timeout_q, timeout_d;
    logic                  done_q, done_d;
    logic [NUM_STAGES-1:0] stage_rst_q, stage_rst_d;
    logic                  wdt_expire;

`ifdef POSIT_MUL_WDT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count the cycles an accepted operation has spent waiting on the pipeline
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_IDLE && start) begin
            cnt_d = '0;
        end else if (state_q == S_DECODE || state_q == S_RUN) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign wdt_expire = (state_q == S_DECODE || state_q == S_RUN) && (cnt_q == CNT_LAST);

    // Watchdog counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign wdt_expire = 1'b0;
`endif

    // Next-state and next-output decisions; NaR always outranks zero
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        nar_d     = nar_q;
        zero_d    = zero_q;
        timeout_d = timeout_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_DECODE;
                    result_d  = '0;
                    nar_d     = 1'b0;
                    zero_d    = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            S_DECODE: begin
                if (dec_valid) begin
                    if (nar_a || nar_b) begin
                        state_d  = S_SPECIAL;
                        result_d = NAR_PATTERN;
                        nar_d    = 1'b1;
                        zero_d   = 1'b0;
                    end else if (zero_a || zero_b) begin
                        state_d  = S_SPECIAL;
                        result_d = '0;
                        nar_d    = 1'b0;
                        zero_d   = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (exp_valid && nar_exp) begin
                    state_d  = S_SPECIAL;
                    result_d = NAR_PATTERN;
                    nar_d    = 1'b1;
                    zero_d   = 1'b0;
                end else if (exp_valid && zero_exp) begin
                    state_d  = S_SPECIAL;
                    result_d = '0;
                    nar_d    = 1'b0;
                    zero_d   = 1'b1;
                end else if (enc_done) begin
                    state_d  = S_DONE;
                    result_d = enc_result;
                    nar_d    = 1'b0;
                    zero_d   = 1'b0;
                end
            end
            S_SPECIAL: state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        if (wdt_expire && (state_d == S_DECODE || state_d == S_RUN)) begin
            state_d   = S_DONE;
            result_d  = NAR_PATTERN;
            nar_d     = 1'b1;
            zero_d    = 1'b0;
            timeout_d = 1'b1;
        end

        stage_rst_d = (state_d == S_DECODE || state_d == S_RUN) ? {NUM_STAGES{1'b1}}
                                                                : {NUM_STAGES{1'b0}};
        done_d      = (state_d == S_DONE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            result_q    <= '0;
            nar_q       <= 1'b0;
            zero_q      <= 1'b0;
            timeout_q   <= 1'b0;
            done_q      <= 1'b0;
            stage_rst_q <= '0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            nar_q       <= nar_d;
            zero_q      <= zero_d;
            timeout_q   <= timeout_d;
            done_q      <= done_d;
            stage_rst_q <= stage_rst_d;
        end
    end

    assign ready       = (state_q == S_IDLE);
    assign stage_rst_n = stage_rst_q;
    assign result      = result_q;
    assign nar         = nar_q;
    assign zero        = zero_q;
    assign done        = done_q;
    assign timeout     = timeout_q;

endmodule
